// File: rtl/gan_ctrl_pkg.sv
// Shared constants and state encoding for the 2->3->9 generator sequencer.
package gan_ctrl_pkg;

    localparam int unsigned Q_W       = 16;
    localparam int unsigned NUM_PIX   = 9;
    localparam int unsigned NUM_NOISE = 2;
    localparam int unsigned PIX_IDX_W = 4;
    localparam int unsigned SETTLE_W  = 4;

    localparam logic [PIX_IDX_W-1:0] LAST_PIX_IDX = PIX_IDX_W'(NUM_PIX - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_STREAM,
        ST_DONE
    } state_e;

    // Sideband that travels with every streamed pixel.
    typedef struct packed {
        logic [PIX_IDX_W-1:0] idx;
        logic                 last;
        logic                 img_last;
    } pix_tag_t;

endpackage

// File: rtl/generator_ctrl_serializer.sv
// Captures the 9 generator outputs and streams them one per valid/ready handshake,
// tagging pixel 8 with pix_last (and img_last on the final image of the batch).
module generator_ctrl_serializer
    import gan_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = Q_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 capture,
    input  logic [DATA_W-1:0]    image [NUM_PIX],
    input  logic                 final_img,
    input  logic                 pix_ready,
    output logic                 pix_valid,
    output logic [DATA_W-1:0]    pix_data,
    output logic [PIX_IDX_W-1:0] pix_idx,
    output logic                 pix_last,
    output logic                 img_last,
    output logic                 img_done_c
);

    logic [DATA_W-1:0] cap_q [NUM_PIX];
    logic [DATA_W-1:0] cap_d [NUM_PIX];
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    pix_tag_t          tag_q, tag_d;
    logic              hs_c;

    assign hs_c       = valid_q && pix_ready;
    assign img_done_c = hs_c && tag_q.last;

    // Next capture/index/output state; outputs hold while the sink stalls.
    always_comb begin
        cap_d   = cap_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (capture) begin
            cap_d     = image;
            valid_d   = 1'b1;
            tag_d.idx = '0;
        end else if (hs_c) begin
            if (tag_q.last) begin
                valid_d   = 1'b0;
                tag_d.idx = '0;
            end else begin
                tag_d.idx = tag_q.idx + 1'b1;
            end
        end
        tag_d.last     = valid_d && (tag_d.idx == LAST_PIX_IDX);
        tag_d.img_last = tag_d.last && final_img;
        data_d         = valid_d ? cap_d[tag_d.idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q   <= '{default: '0};
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            cap_q   <= cap_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    assign pix_valid = valid_q;
    assign pix_data  = data_q;
    assign pix_idx   = tag_q.idx;
    assign pix_last  = tag_q.last;
    assign img_last  = tag_q.img_last;

endmodule

// File: rtl/generator_ctrl.sv
// Batch sequencer for the combinational generator: load noise, settle, capture, stream 9 pixels.
// Optional GEN_CTRL_STALL_CNT_EN adds a saturating 32-bit stall_cnt output.
module generator_ctrl
    import gan_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W        = Q_W,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned BATCH_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BATCH_W-1:0]   batch_len,
    input  logic                 noise_valid,
    output logic                 noise_ready,
    input  logic [DATA_W-1:0]    noise_in_0,
    input  logic [DATA_W-1:0]    noise_in_1,
    output logic [DATA_W-1:0]    gen_noise_0,
    output logic [DATA_W-1:0]    gen_noise_1,
    input  logic [DATA_W-1:0]    gen_image_0,
    input  logic [DATA_W-1:0]    gen_image_1,
    input  logic [DATA_W-1:0]    gen_image_2,
    input  logic [DATA_W-1:0]    gen_image_3,
    input  logic [DATA_W-1:0]    gen_image_4,
    input  logic [DATA_W-1:0]    gen_image_5,
    input  logic [DATA_W-1:0]    gen_image_6,
    input  logic [DATA_W-1:0]    gen_image_7,
    input  logic [DATA_W-1:0]    gen_image_8,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [DATA_W-1:0]    pix_data,
    output logic [PIX_IDX_W-1:0] pix_idx,
    output logic                 pix_last,
    output logic                 img_last,
    output logic                 busy,
    output logic                 done
`ifdef GEN_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [BATCH_W-1:0] batch_len_q, batch_len_d;
    logic [BATCH_W-1:0] img_cnt_q, img_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [DATA_W-1:0]  gen_noise_q [NUM_NOISE];
    logic [DATA_W-1:0]  gen_noise_d [NUM_NOISE];
    logic               noise_ready_q, noise_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               start_acc_c;
    logic               noise_acc_c;
    logic               settle_end_c;
    logic               final_img_c;
    logic               img_done_c;
    logic [DATA_W-1:0]  image_c [NUM_PIX];

    assign image_c[0] = gen_image_0;
    assign image_c[1] = gen_image_1;
    assign image_c[2] = gen_image_2;
    assign image_c[3] = gen_image_3;
    assign image_c[4] = gen_image_4;
    assign image_c[5] = gen_image_5;
    assign image_c[6] = gen_image_6;
    assign image_c[7] = gen_image_7;
    assign image_c[8] = gen_image_8;

    // noise_ready_q is high exactly while in LOAD, so it doubles as the state qualifier.
    assign start_acc_c  = start && (state_q == ST_IDLE);
    assign noise_acc_c  = noise_valid && noise_ready_q;
    assign settle_end_c = (state_q == ST_SETTLE) && (settle_cnt_q == SETTLE_LAST);
    assign final_img_c  = (img_cnt_q == BATCH_W'(batch_len_q - 1'b1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = (batch_len != '0) ? ST_LOAD : ST_DONE;
            ST_LOAD:   if (noise_acc_c) state_d = ST_SETTLE;
            ST_SETTLE: if (settle_end_c) state_d = ST_STREAM;
            ST_STREAM: if (img_done_c) state_d = final_img_c ? ST_DONE : ST_LOAD;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Counters, noise drive and registered status outputs.
    always_comb begin
        batch_len_d  = batch_len_q;
        img_cnt_d    = img_cnt_q;
        settle_cnt_d = settle_cnt_q;
        gen_noise_d  = gen_noise_q;
        if (start_acc_c) begin
            batch_len_d = batch_len;
            img_cnt_d   = '0;
        end
        if (noise_acc_c) begin
            gen_noise_d[0] = noise_in_0;
            gen_noise_d[1] = noise_in_1;
            settle_cnt_d   = '0;
        end
        if (state_q == ST_SETTLE) begin
            settle_cnt_d = settle_cnt_q + 1'b1;
        end
        if ((state_q == ST_STREAM) && img_done_c && !final_img_c) begin
            img_cnt_d = img_cnt_q + 1'b1;
        end
        noise_ready_d = (state_d == ST_LOAD);
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            batch_len_q   <= '0;
            img_cnt_q     <= '0;
            settle_cnt_q  <= '0;
            gen_noise_q   <= '{default: '0};
            noise_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            batch_len_q   <= batch_len_d;
            img_cnt_q     <= img_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            gen_noise_q   <= gen_noise_d;
            noise_ready_q <= noise_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    generator_ctrl_serializer #(
        .DATA_W (DATA_W)
    ) u_serializer (
        .clk        (clk),
        .rst        (rst),
        .capture    (settle_end_c),
        .image      (image_c),
        .final_img  (final_img_c),
        .pix_ready  (pix_ready),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_idx    (pix_idx),
        .pix_last   (pix_last),
        .img_last   (img_last),
        .img_done_c (img_done_c)
    );

    assign noise_ready = noise_ready_q;
    assign gen_noise_0 = gen_noise_q[0];
    assign gen_noise_1 = gen_noise_q[1];
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef GEN_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of sink back-pressure cycles, restarted per batch.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_acc_c) begin
            stall_cnt_d = '0;
        end else if (pix_valid && !pix_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_generator_ctrl.sv
// Bench for generator_ctrl: a time-varying generator stand-in plus a per-batch timeline model.
module tb_generator_ctrl;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  batch_len;
    logic        noise_valid;
    logic        noise_ready;
    logic [15:0] noise_in_0, noise_in_1;
    logic [15:0] gen_noise_0, gen_noise_1;
    logic [15:0] gimg [9];
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic [3:0]  pix_idx;
    logic        pix_last, img_last, busy, done;
`ifdef GEN_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_gn0 = '0;
    logic [15:0] exp_gn1 = '0;
    int          exp_stall = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Generator output depends on its inputs and on time, so capture timing is visible.
    function automatic logic [15:0] gen_pix(input logic [15:0] n0, input logic [15:0] n1,
                                            input int k, input int c);
        return 16'(n0 * (k + 1)) ^ 16'(n1 + 16'(k) * 16'h1111) ^ 16'(c * 3);
    endfunction

    always_comb for (int k = 0; k < 9; k++) gimg[k] = gen_pix(gen_noise_0, gen_noise_1, k, cyc);

    generator_ctrl #(
        .DATA_W        (16),
        .SETTLE_CYCLES (SETTLE),
        .BATCH_W       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .batch_len   (batch_len),
        .noise_valid (noise_valid),
        .noise_ready (noise_ready),
        .noise_in_0  (noise_in_0),
        .noise_in_1  (noise_in_1),
        .gen_noise_0 (gen_noise_0),
        .gen_noise_1 (gen_noise_1),
        .gen_image_0 (gimg[0]),
        .gen_image_1 (gimg[1]),
        .gen_image_2 (gimg[2]),
        .gen_image_3 (gimg[3]),
        .gen_image_4 (gimg[4]),
        .gen_image_5 (gimg[5]),
        .gen_image_6 (gimg[6]),
        .gen_image_7 (gimg[7]),
        .gen_image_8 (gimg[8]),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_idx     (pix_idx),
        .pix_last    (pix_last),
        .img_last    (img_last),
        .busy        (busy),
        .done        (done)
`ifdef GEN_CTRL_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, 32'(pix_valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_nrdy"}, 32'(noise_ready), 0);
        check({tag, "_gnoise"}, {gen_noise_0, gen_noise_1}, {exp_gn0, exp_gn1});
`ifdef GEN_CTRL_STALL_CNT_EN
        check({tag, "_stall"}, stall_cnt, 32'(exp_stall));
`endif
    endtask

    // One batch from start to done (or to a reset injected at a chosen pixel).
    task automatic run_batch(input int n, input int rmode, input int dmin, input int dmax,
                             input bit fixed, input bit busy_start,
                             input int abort_img, input int abort_pix);
        logic [15:0] n0, n1;
        logic [15:0] exp_pix [9];
        int          a, d, p, g;
        bit          rdy;
        batch_len = 8'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        batch_len = 8'($urandom);
        exp_stall = 0;
        if (n == 0) begin
            check("zero_done", 32'(done), 1);
            check("zero_nrdy", 32'(noise_ready), 0);
            tick();
            check_quiet("zero_after");
            return;
        end
        noise_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("load_nrdy", 32'(noise_ready), 1);
            check("load_valid", 32'(pix_valid), 0);
`ifdef GEN_CTRL_STALL_CNT_EN
            if (i == 0) check("start_stall_clr", stall_cnt, 0);
`endif
            n0 = fixed ? 16'h4000 : 16'($urandom);
            n1 = fixed ? 16'hC000 : 16'($urandom);
            noise_in_0 = n0;
            noise_in_1 = n1;
            d = $urandom_range(dmax, dmin);
            for (int w = 0; w < d; w++) begin
                noise_valid = 1'b0;
                if (busy_start && w == 0) begin
                    start     = 1'b1;
                    batch_len = 8'($urandom);
                end
                tick();
                start = 1'b0;
                check("wait_nrdy", 32'(noise_ready), 1);
                check("wait_gnoise", {gen_noise_0, gen_noise_1}, {exp_gn0, exp_gn1});
            end
            noise_valid = 1'b1;
            a = cyc;
            tick();
            if (dmax != 0) noise_valid = 1'b0;
            exp_gn0 = n0;
            exp_gn1 = n1;
            check("accept_gnoise", {gen_noise_0, gen_noise_1}, {exp_gn0, exp_gn1});
            check("accept_nrdy", 32'(noise_ready), 0);
            for (int k = 0; k < 9; k++) exp_pix[k] = gen_pix(n0, n1, k, a + SETTLE);
            for (int s = 0; s < SETTLE; s++) begin
                check("settle_valid", 32'(pix_valid), 0);
                check("settle_busy", 32'(busy), 1);
                tick();
            end
            p = 0;
            g = 0;
            while (p < 9 && g < 200) begin
                rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((g % 2) == 0) : 1'($urandom);
                pix_ready = rdy;
                check("pix_valid", 32'(pix_valid), 1);
                check("pix_idx", 32'(pix_idx), 32'(p));
                check("pix_data", 32'(pix_data), 32'(exp_pix[p]));
                check("pix_last", 32'(pix_last), 32'(p == 8));
                check("img_last", 32'(img_last), 32'(p == 8 && i == n - 1));
                if (i == abort_img && p == abort_pix) begin
                    rst = 1'b1;
                    tick();
                    exp_gn0 = '0;
                    exp_gn1 = '0;
                    exp_stall = 0;
                    check_quiet("abort");
                    rst = 1'b0;
                    noise_valid = 1'b0;
                    for (int q = 0; q < 4; q++) begin
                        tick();
                        check("abort_no_done", 32'(done), 0);
                        check("abort_idle", 32'(busy), 0);
                    end
                    return;
                end
                if (!rdy) exp_stall++;
                tick();
                if (rdy) p++;
                g++;
            end
            check("stream_complete", 32'(p), 9);
            pix_ready = 1'($urandom);
            check("post_valid", 32'(pix_valid), 0);
            if (i == n - 1) begin
                check("done_pulse", 32'(done), 1);
                check("done_busy", 32'(busy), 1);
                check("done_nrdy", 32'(noise_ready), 0);
            end else begin
                check("mid_no_done", 32'(done), 0);
            end
        end
        noise_valid = 1'b0;
        tick();
        check_quiet("batch_end");
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        batch_len   = '0;
        noise_valid = 1'b0;
        noise_in_0  = '0;
        noise_in_1  = '0;
        pix_ready   = 1'b0;
        repeat (3) tick();
        check_quiet("in_reset");
        rst = 1'b0;
        tick();
        check_quiet("after_reset");

        run_batch(0, 0, 0, 0, 1'b0, 1'b0, -1, -1);
        run_batch(1, 0, 0, 0, 1'b1, 1'b0, -1, -1);
        run_batch(3, 0, 0, 0, 1'b0, 1'b0, -1, -1);
        run_batch(2, 1, 0, 0, 1'b0, 1'b0, -1, -1);
        run_batch(2, 0, 5, 5, 1'b0, 1'b1, -1, -1);
        run_batch(3, 2, 0, 2, 1'b0, 1'b0, 1, 4);
        run_batch(2, 2, 0, 3, 1'b0, 1'b0, -1, -1);
        for (int r = 0; r < 6; r++) begin
            run_batch(int'($urandom_range(6, 1)), int'($urandom_range(2, 0)),
                      0, 4, 1'b0, 1'($urandom), -1, -1);
        end
        run_batch(255, 0, 0, 0, 1'b0, 1'b0, -1, -1);
        run_batch(0, 0, 0, 0, 1'b0, 1'b0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: observed cycle %0d, expected completion", cyc);
        $fatal(1, "bench timeout");
    end

endmodule
